// File: rtl/mult_div_pkg.sv
// Shared types and constants for the HI/LO multiply/divide units.
// Holds the FSM states, sizes and Booth operation encoding.
package mult_div_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = 6;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        NOP,
        ADD,
        SUB
    } booth_op_e;

    // Radix-2 Booth recoding of the pair {q[0], q_-1}.
    function automatic booth_op_e booth_op(input logic q0, input logic qm1);
        unique case ({q0, qm1})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub the multiplicand,
// then arithmetic right shift of {acc, q, q_-1} by one.
module booth_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   mcand,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_m1_nxt
);

    logic [WIDTH:0] sum;

    // Recode, add/subtract modulo 2^(WIDTH+1), then shift with sign fill.
    always_comb begin
        sum = acc;
        unique case (booth_op(q[0], q_m1))
            ADD:     sum = acc + mcand;
            SUB:     sum = acc - mcand;
            default: sum = acc;
        endcase
        acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt    = {sum[0], q[WIDTH-1:1]};
        q_m1_nxt = q[0];
    end

endmodule

// File: rtl/booth_mult.sv
// Sequential signed Booth multiplier feeding the HI/LO registers.
// One Booth step per clock; product is registered on completion.
module booth_mult #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mult_in,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             mult_out,
    output logic             busy
);

    import mult_div_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             qm1_nxt;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .q        (q_q),
        .q_m1     (qm1_q),
        .mcand    (mcand_q),
        .acc_nxt  (acc_nxt),
        .q_nxt    (q_nxt),
        .q_m1_nxt (qm1_nxt)
    );

    // Next-state: capture operands in IDLE, step and finish in RUN.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mult_in) begin
                    state_d = RUN;
                    mcand_d = {A[WIDTH-1], A};
                    acc_d   = '0;
                    q_d     = B;
                    qm1_d   = 1'b0;
                    count_d = '0;
                end
            end
            RUN: begin
                acc_d   = acc_nxt;
                q_d     = q_nxt;
                qm1_d   = qm1_nxt;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    hi_d    = acc_nxt[WIDTH-1:0];
                    lo_d    = q_nxt;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything including HI/LO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign mult_out = done_q;
    assign busy     = (state_q == RUN);

endmodule
